// File: rtl/division_secuencial_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encoding, default operand width and iteration counter sizing.
package division_secuencial_pkg;

  localparam int ANCHO_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  // Counter must hold the value ANCHO itself, hence ANCHO+1 codes.
  function automatic int cnt_ancho(input int ancho);
    return $clog2(ancho + 1);
  endfunction

endpackage

// File: rtl/division_secuencial_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// The requester uses the master modport, the divider the slave modport.
interface division_secuencial_if
  import division_secuencial_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
);
  logic             inicio;
  logic [ANCHO-1:0] dividendo;
  logic [ANCHO-1:0] divisor;
  logic             ocupado;
  logic             listo;
  logic [ANCHO-1:0] cociente;
  logic [ANCHO-1:0] residuo;
  logic             div_cero;

  modport master (
    output inicio, dividendo, divisor,
    input  ocupado, listo, cociente, residuo, div_cero
  );

  modport slave (
    input  inicio, dividendo, divisor,
    output ocupado, listo, cociente, residuo, div_cero
  );
endinterface

// File: rtl/division_secuencial_paso_division.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract D.
// The trial value is formed at ANCHO+1 bits; its MSB is the borrow (negative result).
module division_secuencial_paso_division #(
  parameter int ANCHO = 4
) (
  input  logic [ANCHO-1:0] r_i,
  input  logic [ANCHO-1:0] q_i,
  input  logic [ANCHO-1:0] d_i,
  output logic [ANCHO-1:0] r_o,
  output logic [ANCHO-1:0] q_o
);

  logic [ANCHO:0] desplazado_s;
  logic [ANCHO:0] prueba_s;

  // Trial subtract; the stored remainder always stays below D, so ANCHO bits suffice between steps.
  always_comb begin
    desplazado_s = {r_i, q_i[ANCHO-1]};
    prueba_s     = desplazado_s - {1'b0, d_i};
    if (prueba_s[ANCHO] == 1'b0) begin
      r_o = prueba_s[ANCHO-1:0];
      q_o = {q_i[ANCHO-2:0], 1'b1};
    end else begin
      r_o = desplazado_s[ANCHO-1:0];
      q_o = {q_i[ANCHO-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/division_secuencial.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Operands are captured on an accepted start; results hold until the next completion.
module division_secuencial
  import division_secuencial_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  division_secuencial_if.slave  bus
);

  localparam int CNT_W = cnt_ancho(ANCHO);

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] r_q, r_d;
  logic [ANCHO-1:0] q_q, q_d;
  logic [ANCHO-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ANCHO-1:0] cociente_q, cociente_d;
  logic [ANCHO-1:0] residuo_q, residuo_d;
  logic             div_cero_q, div_cero_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic [ANCHO-1:0] r_sig_s;
  logic [ANCHO-1:0] q_sig_s;

  division_secuencial_paso_division #(.ANCHO(ANCHO)) u_paso_division (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_sig_s),
    .q_o (q_sig_s)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    estado_d   = estado_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    div_cero_d = div_cero_q;
    case (estado_q)
      REPOSO, FIN: begin
        if (bus.inicio) begin
          q_d   = bus.dividendo;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = CNT_W'(ANCHO);
          if (bus.divisor == '0) begin
            estado_d   = FIN;
            cociente_d = '1;
            residuo_d  = bus.dividendo;
            div_cero_d = 1'b1;
          end else begin
            estado_d = CALCULO;
          end
        end else begin
          estado_d = REPOSO;
        end
      end
      CALCULO: begin
        r_d   = r_sig_s;
        q_d   = q_sig_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          estado_d   = FIN;
          cociente_d = q_sig_s;
          residuo_d  = r_sig_s;
          div_cero_d = 1'b0;
        end else begin
          estado_d = CALCULO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
    ocupado_d = (estado_d == CALCULO);
    listo_d   = (estado_d == FIN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= REPOSO;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      div_cero_q <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      div_cero_q <= div_cero_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
    end
  end

  assign bus.ocupado  = ocupado_q;
  assign bus.listo    = listo_q;
  assign bus.cociente = cociente_q;
  assign bus.residuo  = residuo_q;
  assign bus.div_cero = div_cero_q;

endmodule

// File: tb/tb_division_secuencial.sv
// Self-checking bench for division_secuencial at ANCHO=4 and ANCHO=8.
// Directed table, handshake corner sequences, exhaustive 4-bit and random 8-bit sweeps.
module tb_division_secuencial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  division_secuencial_if #(.ANCHO(4)) if4 ();
  division_secuencial_if #(.ANCHO(8)) if8 ();

  division_secuencial #(.ANCHO(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  division_secuencial #(.ANCHO(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Waits from the negedge right after the accepting edge until listo; returns edges waited and busy cycles.
  task automatic wait_listo4(output int e, output int oc);
    e = 0; oc = 0;
    while (!if4.listo && e < 40) begin
      if (if4.ocupado) oc++;
      @(negedge clk);
      e++;
    end
  endtask

  task automatic div4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                      input logic [3:0] er, input logic edz, input int elat, input string nm);
    int e, oc;
    @(negedge clk);
    if4.dividendo = a; if4.divisor = b; if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;
    wait_listo4(e, oc);
    chk({nm, " listo"}, int'(if4.listo), 1);
    chk({nm, " latency"}, e, elat);
    chk({nm, " busy_cycles"}, oc, elat);
    chk({nm, " ocupado_at_listo"}, int'(if4.ocupado), 0);
    chk({nm, " cociente"}, int'(if4.cociente), int'(eq));
    chk({nm, " residuo"}, int'(if4.residuo), int'(er));
    chk({nm, " div_cero"}, int'(if4.div_cero), int'(edz));
    @(negedge clk);
    chk({nm, " listo_pulse"}, int'(if4.listo), 0);
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b);
    int e;
    int eq, er, edz;
    @(negedge clk);
    if8.dividendo = a; if8.divisor = b; if8.inicio = 1'b1;
    @(negedge clk);
    if8.inicio = 1'b0;
    e = 0;
    while (!if8.listo && e < 60) begin
      @(negedge clk);
      e++;
    end
    if (b == 8'd0) begin
      eq = 255; er = int'(a); edz = 1;
    end else begin
      eq = int'(a) / int'(b); er = int'(a) % int'(b); edz = 0;
    end
    chk($sformatf("d8 %0d/%0d latency", a, b), e, (b == 8'd0) ? 0 : 8);
    chk($sformatf("d8 %0d/%0d cociente", a, b), int'(if8.cociente), eq);
    chk($sformatf("d8 %0d/%0d residuo", a, b), int'(if8.residuo), er);
    chk($sformatf("d8 %0d/%0d div_cero", a, b), int'(if8.div_cero), edz);
  endtask

  initial begin
    vec_t tabla[8];
    int e, oc;
    tabla[0] = '{4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 4};
    tabla[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4};
    tabla[2] = '{4'd3,  4'd9, 4'd0,  4'd3, 1'b0, 4};
    tabla[3] = '{4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 0};
    tabla[4] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 4};
    tabla[5] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4};
    tabla[6] = '{4'd0,  4'd0, 4'hF,  4'd0, 1'b1, 0};
    tabla[7] = '{4'd9,  4'd2, 4'd4,  4'd1, 1'b0, 4};

    if4.inicio = 1'b0; if4.dividendo = 4'd0; if4.divisor = 4'd0;
    if8.inicio = 1'b0; if8.dividendo = 8'd0; if8.divisor = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset ocupado", int'(if4.ocupado), 0);
    chk("reset listo", int'(if4.listo), 0);
    chk("reset cociente", int'(if4.cociente), 0);
    chk("reset residuo", int'(if4.residuo), 0);
    chk("reset div_cero", int'(if4.div_cero), 0);

    for (int i = 0; i < 8; i++)
      div4(tabla[i].a, tabla[i].b, tabla[i].q, tabla[i].r, tabla[i].dz, tabla[i].lat,
           $sformatf("tab%0d", i));

    // Results must hold while idle.
    repeat (5) @(negedge clk);
    chk("hold cociente", int'(if4.cociente), 4);
    chk("hold residuo", int'(if4.residuo), 1);
    chk("hold listo", int'(if4.listo), 0);

    // Restart during CALCULO is ignored; restart in the listo cycle is accepted.
    if4.dividendo = 4'd12; if4.divisor = 4'd5; if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;
    @(negedge clk);
    if4.dividendo = 4'd9; if4.divisor = 4'd3; if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;
    chk("ign cociente_held", int'(if4.cociente), 4);
    e = 2;
    while (!if4.listo && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk("ign latency", e, 4);
    chk("ign cociente", int'(if4.cociente), 2);
    chk("ign residuo", int'(if4.residuo), 2);
    if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;
    chk("b2b ocupado", int'(if4.ocupado), 1);
    chk("b2b listo", int'(if4.listo), 0);
    chk("b2b cociente_held", int'(if4.cociente), 2);
    wait_listo4(e, oc);
    chk("b2b latency", e, 4);
    chk("b2b cociente", int'(if4.cociente), 3);
    chk("b2b residuo", int'(if4.residuo), 0);

    // Reset at the second CALCULO edge abandons the division.
    @(negedge clk);
    if4.dividendo = 4'd14; if4.divisor = 4'd3; if4.inicio = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid ocupado", int'(if4.ocupado), 0);
    chk("rstmid cociente", int'(if4.cociente), 0);
    chk("rstmid residuo", int'(if4.residuo), 0);
    oc = 0;
    for (int i = 0; i < 8; i++) begin
      if (if4.listo || if4.ocupado) oc++;
      @(negedge clk);
    end
    chk("rstmid no_listo", oc, 0);
    div4(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4, "after_rst");

    // Simultaneous rst and inicio: reset wins.
    if4.dividendo = 4'd7; if4.divisor = 4'd0; if4.inicio = 1'b1; rst = 1'b1;
    @(negedge clk);
    if4.inicio = 1'b0; rst = 1'b0;
    chk("rst_vs_inicio listo", int'(if4.listo), 0);
    chk("rst_vs_inicio div_cero", int'(if4.div_cero), 0);
    chk("rst_vs_inicio residuo", int'(if4.residuo), 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        div4(4'(a), 4'(b), (b == 0) ? 4'hF : 4'(a / b), (b == 0) ? 4'(a) : 4'(a % b),
             (b == 0) ? 1'b1 : 1'b0, (b == 0) ? 0 : 4, $sformatf("exh4 %0d/%0d", a, b));

    div8(8'd255, 8'd1);
    div8(8'd255, 8'd255);
    div8(8'd200, 8'd0);
    div8(8'd1, 8'd200);
    for (int i = 0; i < 150; i++)
      div8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
